// File: rtl/sub32_serial.sv
// 32-bit subtractor computing a - b - bin one 4-bit slice per clock.
// Operands are captured on start; results update only on the final slice.
module sub32_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic [31:0] diff,
    output logic        bout,
    output logic        of,
    output logic        busy,
    output logic        done
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    logic        state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        bin_q, bin_d;
    logic [31:0] diff_q, diff_d;
    logic        bout_q, bout_d;
    logic        of_q, of_d;
    logic        done_q, done_d;

    logic [4:0]  bit_base;
    logic [3:0]  a_slice;
    logic [3:0]  b_slice;
    logic        c_in;
    logic [4:0]  slice_sum;

    // Subtraction as a + ~b + ~bin; carry-out of 1 means no borrow.
    assign bit_base  = {idx_q, 2'b00};
    assign a_slice   = a_q[bit_base +: 4];
    assign b_slice   = b_q[bit_base +: 4];
    assign c_in      = (idx_q == 3'd0) ? ~bin_q : carry_q;
    assign slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {4'b0000, c_in};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        bin_d   = bin_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        of_d    = of_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = bin;
                    idx_d   = 3'd0;
                    carry_d = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d[bit_base +: 4] = slice_sum[3:0];
                carry_d              = slice_sum[4];
                idx_d                = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    diff_d  = acc_d;
                    bout_d  = ~slice_sum[4];
                    of_d    = (a_q[31] ^ b_q[31]) & (slice_sum[3] ^ a_q[31]);
                    done_d  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            carry_q <= 1'b0;
            acc_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            bin_q   <= 1'b0;
            diff_q  <= 32'd0;
            bout_q  <= 1'b0;
            of_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bin_q   <= bin_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            of_q    <= of_d;
            done_q  <= done_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign of   = of_q;
    assign busy = (state_q == S_BUSY);
    assign done = done_q;

endmodule
